// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the IF stage: bus widths, reset PC, fetch FSM encoding
// and the {pc, inst, exc} entry carried from the fetch buffer into IF/ID.
package if_fetch_unit_pkg;

  typedef logic [7:0]  stall_bus_t;
  typedef logic [31:0] reg_bus_t;

  localparam reg_bus_t ZERO_WORD        = 32'h0000_0000;
  localparam reg_bus_t RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam reg_bus_t EXC_ADEL_DEFAULT = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    reg_bus_t pc;
    reg_bus_t inst;
    reg_bus_t exc;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32 with no trap.
  function automatic reg_bus_t pc_plus4(input reg_bus_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit_inst_buf.sv
// One-entry holding buffer between the instruction bus and IF/ID.
// Clear beats load, load beats consume, so a refill in the consume cycle keeps the entry valid.
module if_inst_buf
  import if_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         consume_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q;

  always_comb begin
    valid_d = valid_q;
    if (clear_i)        valid_d = 1'b0;
    else if (load_i)    valid_d = 1'b1;
    else if (consume_i) valid_d = 1'b0;
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the payload is not reset; valid_q alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (load_i && !clear_i) entry_q <= entry_i;
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, keeps one fetch outstanding on the inst SRAM-like port, and feeds IF/ID.
// Handles flush/new_pc redirects and ID branches while preserving the MIPS delay slot.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter reg_bus_t RESET_PC = RESET_PC_DEFAULT,
  parameter reg_bus_t EXC_ADEL = EXC_ADEL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  stall_bus_t stall,
  input  logic       flush,
  input  reg_bus_t   new_pc,
  input  logic       br_e,
  input  reg_bus_t   br_addr,
  input  reg_bus_t   id_pc,
  output logic       inst_sram_req,
  output reg_bus_t   inst_sram_addr,
  input  logic       inst_sram_addr_ok,
  input  logic       inst_sram_data_ok,
  input  reg_bus_t   inst_sram_rdata,
  output logic       stallreq_from_if,
  output reg_bus_t   if_pc,
  output reg_bus_t   if_inst,
  output logic       if_valid,
  output reg_bus_t   if_excepttype
);

  fetch_state_e state_q, state_d;
  reg_bus_t     pc_q, pc_d;
  reg_bus_t     inflight_q, inflight_d;
  reg_bus_t     pend_q, pend_d;
  logic         pend_v_q, pend_v_d;
  logic         halt_q, halt_d;

  logic         buf_valid, buf_load;
  fetch_entry_t buf_entry, buf_load_entry;
  fetch_entry_t ifid_q;
  logic         if_valid_q;

  logic         consume, buf_free, fire, br_take, pc_aligned;
  reg_bus_t     ds_pc;

  // Only stall[1] matters here; the request ignores stall[0] to avoid deadlock with stallreq.
  logic unused_stall;
  assign unused_stall = ^{stall[7:2], stall[0]};

  assign consume    = ~stall[1];
  assign buf_free   = ~buf_valid | consume;
  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign ds_pc      = pc_plus4(id_pc);
  assign br_take    = br_e & consume & ~flush;

  assign inst_sram_req  = ~rst & (state_q == ST_IDLE) & pc_aligned & buf_free;
  assign inst_sram_addr = pc_q;
  assign fire           = inst_sram_req & inst_sram_addr_ok;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inflight_d     = inflight_q;
    pend_d         = pend_q;
    pend_v_d       = pend_v_q;
    halt_d         = halt_q;
    buf_load       = 1'b0;
    buf_load_entry = '{pc: inflight_q, inst: inst_sram_rdata, exc: ZERO_WORD};

    if (flush) begin
      pc_d     = new_pc;
      pend_v_d = 1'b0;
      halt_d   = 1'b0;
      unique case (state_q)
        ST_IDLE: state_d = fire ? ST_DROP : ST_IDLE;
        ST_WAIT,
        ST_DROP: state_d = inst_sram_data_ok ? ST_IDLE : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fire) begin
            inflight_d = pc_q;
            pc_d       = pend_v_q ? pend_q : pc_plus4(pc_q);
            pend_v_d   = 1'b0;
            state_d    = ST_WAIT;
          end else if (!pc_aligned && !halt_q && buf_free) begin
            buf_load       = 1'b1;
            buf_load_entry = '{pc: pc_q, inst: ZERO_WORD, exc: EXC_ADEL};
            halt_d         = 1'b1;
          end
        end
        ST_WAIT: begin
          if (inst_sram_data_ok) begin
            buf_load = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (inst_sram_data_ok) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // The delay slot survives a branch; anything fetched past it is squashed.
      if (br_take) begin
        if (pc_q == ds_pc) begin
          if (fire) begin
            pc_d     = br_addr;
            pend_v_d = 1'b0;
          end else begin
            pend_d   = br_addr;
            pend_v_d = 1'b1;
          end
        end else begin
          pc_d     = br_addr;
          pend_v_d = 1'b0;
          if (fire) begin
            state_d = ST_DROP;
          end else if (state_q == ST_WAIT && inflight_q != ds_pc) begin
            buf_load = 1'b0;
            state_d  = inst_sram_data_ok ? ST_IDLE : ST_DROP;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= ZERO_WORD;
      pend_q     <= ZERO_WORD;
      pend_v_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      halt_q     <= halt_d;
    end
  end

  if_inst_buf u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (flush),
    .load_i    (buf_load),
    .consume_i (consume),
    .entry_i   (buf_load_entry),
    .valid_o   (buf_valid),
    .entry_o   (buf_entry)
  );

  // Bubbles enter IF/ID as all-zero so downstream never sees stale payload.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ifid_q     <= '0;
      if_valid_q <= 1'b0;
    end else if (consume) begin
      ifid_q     <= buf_valid ? buf_entry : '0;
      if_valid_q <= buf_valid;
    end
  end

  assign stallreq_from_if = ~buf_valid & ~flush;
  assign if_pc            = ifid_q.pc;
  assign if_inst          = ifid_q.inst;
  assign if_excepttype    = ifid_q.exc;
  assign if_valid         = if_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a bus responder logs accepted addresses, and a monitor
// pops expected IF/ID entries from a queue each time IF/ID loads a valid instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] id_pc;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        stallreq_from_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic [31:0] if_excepttype;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .br_e              (br_e),
    .br_addr           (br_addr),
    .id_pc             (id_pc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .stallreq_from_if  (stallreq_from_if),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_valid          (if_valid),
    .if_excepttype     (if_excepttype)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          total = 0;
  int          bad   = 0;
  int          budget = 0;
  int          dok_delay = 1;
  int          cyc = 0;
  int          last_pop = -1;
  logic        gap_chk = 1'b0;
  logic        mon_loaded;
  logic        pend_data = 1'b0;
  int          dcnt = 0;
  logic [31:0] daddr = 32'h0;

  function automatic logic [31:0] tb_inst(input logic [31:0] a);
    return a ^ 32'hffff_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic push_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.inst = tb_inst(pc); e.exc = 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_acc(input string name, input logic [31:0] a);
    if (acc_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: no request accepted, want addr %h", name, a);
    end else begin
      check(name, acc_q.pop_front(), a);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Reset ends at posedge+1 of cycle 0; the bus settings apply from that cycle on.
  task automatic do_reset(input int dok, input int bud);
    @(posedge clk); #1;
    rst = 1'b1; stall = 8'h00; flush = 1'b0; br_e = 1'b0;
    new_pc = 32'h0; br_addr = 32'h0; id_pc = 32'h0; budget = 0;
    exp_q.delete(); acc_q.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; dok_delay = dok; budget = bud;
  endtask

  always @(posedge clk) cyc++;

  // Bus responder: addr_ok in the request cycle, data_ok dok_delay cycles later.
  initial begin
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    forever begin
      @(negedge clk);
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
      if (rst) begin
        pend_data = 1'b0;
      end else if (pend_data) begin
        if (dcnt <= 1) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = tb_inst(daddr);
          pend_data         = 1'b0;
        end else begin
          dcnt--;
        end
      end else if (inst_sram_req && budget > 0) begin
        inst_sram_addr_ok = 1'b1;
        pend_data = 1'b1;
        dcnt      = dok_delay;
        daddr     = inst_sram_addr;
        acc_q.push_back(inst_sram_addr);
        budget--;
      end
    end
  end

  // Monitor: IF/ID presents a new instruction when it loaded (stall[1]=0) and is valid.
  initial begin
    forever begin
      @(posedge clk);
      mon_loaded = !stall[1] && !rst;
      @(negedge clk);
      if (mon_loaded && if_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ifid: got pc %h inst %h, want nothing", if_pc, if_inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_inst", if_inst, e.inst);
          check("if_excepttype", if_excepttype, e.exc);
        end
        if (gap_chk) begin
          if (last_pop >= 0) check("t1_valid_gap", cyc - last_pop, 2);
          last_pop = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int sr_bad;
    int req_seen;
    rst = 1'b1; stall = 8'h00; flush = 1'b0; br_e = 1'b0;
    new_pc = 32'h0; br_addr = 32'h0; id_pc = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_exc", if_excepttype, 0);
    check("rst_req", inst_sram_req, 0);
    check("rst_stallreq", stallreq_from_if, 1);

    // 1: back-to-back fetches, one instruction every two cycles
    do_reset(1, 4);
    gap_chk = 1'b1; last_pop = -1;
    push_fetch(32'hbfc00000); push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00008); push_fetch(32'hbfc0000c);
    drain("t1_drain");
    gap_chk = 1'b0;
    check_acc("t1_acc0", 32'hbfc00000); check_acc("t1_acc1", 32'hbfc00004);
    check_acc("t1_acc2", 32'hbfc00008); check_acc("t1_acc3", 32'hbfc0000c);
    check("t1_acc_left", acc_q.size(), 0);

    // 2: slow response keeps stallreq high until the buffer fills
    do_reset(5, 1);
    push_fetch(32'hbfc00000);
    sr_bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stallreq_from_if !== 1'b1) sr_bad++;
    end
    check("t2_stallreq_while_waiting", sr_bad, 0);
    @(negedge clk);
    check("t2_stallreq_buf_full", stallreq_from_if, 0);
    drain("t2_drain");
    check_acc("t2_acc0", 32'hbfc00000);
    check("t2_acc_left", acc_q.size(), 0);

    // 3: flush while WAIT; the late response for bfc00004 is dropped
    do_reset(3, 3);
    push_fetch(32'hbfc00000); push_fetch(32'hbfc00380);
    repeat (5) @(posedge clk); #1;
    flush = 1'b1; new_pc = 32'hbfc00380;
    @(negedge clk);
    check("t3_stallreq_in_flush", stallreq_from_if, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t3_if_valid_after_flush", if_valid, 0);
    check("t3_pc_redirected", inst_sram_addr, 32'hbfc00380);
    check("t3_no_req_in_drop", inst_sram_req, 0);
    drain("t3_drain");
    check_acc("t3_acc0", 32'hbfc00000); check_acc("t3_acc1", 32'hbfc00004);
    check_acc("t3_acc2", 32'hbfc00380);
    check("t3_acc_left", acc_q.size(), 0);

    // 4: branch at bfc00010 with its delay slot held in the buffer
    do_reset(1, 8);
    push_fetch(32'hbfc00000); push_fetch(32'hbfc00004); push_fetch(32'hbfc00008);
    push_fetch(32'hbfc0000c); push_fetch(32'hbfc00010); push_fetch(32'hbfc00014);
    push_fetch(32'hbfc00100);
    repeat (11) @(posedge clk); #1;
    check("t4_branch_in_ifid", if_pc, 32'hbfc00010);
    stall = 8'h02;
    repeat (2) @(posedge clk); #1;
    check("t4_ds_buffered", stallreq_from_if, 0);
    stall = 8'h00; br_e = 1'b1; id_pc = 32'hbfc00010; br_addr = 32'hbfc00100;
    @(posedge clk); #1;
    br_e = 1'b0;
    drain("t4_drain");
    check_acc("t4_acc0", 32'hbfc00000); check_acc("t4_acc1", 32'hbfc00004);
    check_acc("t4_acc2", 32'hbfc00008); check_acc("t4_acc3", 32'hbfc0000c);
    check_acc("t4_acc4", 32'hbfc00010); check_acc("t4_acc5", 32'hbfc00014);
    check_acc("t4_acc6", 32'hbfc00018); check_acc("t4_acc7", 32'hbfc00100);
    check("t4_acc_left", acc_q.size(), 0);

    // 5: branch while the delay slot has not been fetched yet
    do_reset(1, 5);
    push_fetch(32'hbfc00000); push_fetch(32'hbfc00004); push_fetch(32'hbfc00008);
    push_fetch(32'hbfc0000c); push_fetch(32'hbfc00010); push_fetch(32'hbfc00014);
    push_fetch(32'hbfc00100);
    repeat (11) @(posedge clk); #1;
    check("t5_branch_in_ifid", if_pc, 32'hbfc00010);
    br_e = 1'b1; id_pc = 32'hbfc00010; br_addr = 32'hbfc00100;
    @(posedge clk); #1;
    br_e = 1'b0; budget = 2;
    @(negedge clk);
    check("t5_ds_addr", inst_sram_addr, 32'hbfc00014);
    @(negedge clk);
    check("t5_pending_applied", inst_sram_addr, 32'hbfc00100);
    drain("t5_drain");
    for (int i = 0; i < 5; i++) check_acc("t5_acc_seq", 32'hbfc00000 + 32'(4 * i));
    check_acc("t5_acc_ds", 32'hbfc00014); check_acc("t5_acc_target", 32'hbfc00100);
    check("t5_acc_left", acc_q.size(), 0);

    // 6: flush to a misaligned PC raises AdEL and halts fetching
    do_reset(1, 5);
    begin
      exp_t e;
      e.pc = 32'hbfc00002; e.inst = 32'h0; e.exc = 32'h4;
      exp_q.push_back(e);
    end
    repeat (2) @(posedge clk); #1;
    flush = 1'b1; new_pc = 32'hbfc00002;
    @(posedge clk); #1;
    flush = 1'b0;
    drain("t6_drain");
    req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inst_sram_req !== 1'b0) req_seen++;
    end
    check("t6_no_req_when_misaligned", req_seen, 0);
    check_acc("t6_acc0", 32'hbfc00000); check_acc("t6_acc1", 32'hbfc00004);
    check("t6_acc_left", acc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
